data_memory_responder: RTL and testbench

- Responder end of the pipeline's data-memory interface.
- Accepts one load/store request at a time from the MEM stage over a valid/ready handshake.
- Holds the request for a programmable number of wait states, then returns the read data or write completion over a valid/ready response handshake.
- Handles RV32I access sizes (byte/half/word, signed/unsigned) and flags misaligned or out-of-range accesses.

---
 rtl/data_memory_responder_pkg.sv | 29 ++
 rtl/data_memory_responder_if.sv | 24 ++
 rtl/data_memory_responder_mem_lane_align.sv | 57 +++++
 rtl/data_memory_responder.sv | 128 ++++++++++++
 tb/tb_data_memory_responder.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_responder_pkg.sv
// Shared definitions for the data-memory responder: access size codes,
// FSM state encoding and the default data-segment base address.
package data_memory_responder_pkg;

  // funct3 codes of RV32I loads/stores
  localparam logic [2:0] SIZE_B  = 3'd0;
  localparam logic [2:0] SIZE_H  = 3'd1;
  localparam logic [2:0] SIZE_W  = 3'd2;
  localparam logic [2:0] SIZE_BU = 3'd4;
  localparam logic [2:0] SIZE_HU = 3'd5;

  localparam logic [31:0] DATA_BASE = 32'h1001_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  // Unsigned variants exist only for loads; 3, 6 and 7 are never legal.
  function automatic logic size_legal(input logic write, input logic [2:0] size);
    case (size)
      SIZE_B, SIZE_H, SIZE_W: return 1'b1;
      SIZE_BU, SIZE_HU:       return !write;
      default:                return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Request/response handshake bundle between the MEM stage (master)
// and the data-memory responder (slave).
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_size;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/data_memory_responder_mem_lane_align.sv
// Combinational byte-lane steering: store byte enables and replicated
// write data, extended load data, and the misalignment flag.
module mem_lane_align
  import data_memory_responder_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] raw,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [31:0] shifted;

  assign shifted    = raw >> {addr_lo, 3'b000};
  assign misaligned = ((size[1:0] == 2'd1) && addr_lo[0]) ||
                      ((size[1:0] == 2'd2) && (addr_lo != 2'd0));

  // Store side: replicate the datum into every lane and enable only the target ones
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    byte_en     = 4'b0000;
    wdata_lanes = 32'h0;
    case (size[1:0])
      2'd0: begin
        byte_en     = 4'b0001 << addr_lo;
        wdata_lanes = {4{wdata[7:0]}};
      end
      2'd1: begin
        byte_en     = 4'b0011 << addr_lo;
        wdata_lanes = {2{wdata[15:0]}};
      end
      2'd2: begin
        byte_en     = 4'b1111;
        wdata_lanes = wdata;
      end
      default: ;
    endcase
  end

  // Load side: pick the addressed lane(s) and sign- or zero-extend
  always_comb begin
    load_data = 32'h0;
    case (size)
      SIZE_B:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      SIZE_BU: load_data = {24'h0, shifted[7:0]};
      SIZE_H:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      SIZE_HU: load_data = {16'h0, shifted[15:0]};
      SIZE_W:  load_data = shifted;
      default: load_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: accepts one load/store, waits LATENCY cycles,
// commits on entry to RESP and holds the response until it is taken.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = DATA_BASE,
  parameter int          LATENCY     = 2
) (
  input logic                    clock,
  input logic                    reset,
  data_memory_responder_if.slave bus
);

  localparam int          IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN     = 32'(4 * DEPTH_WORDS);
  localparam logic [3:0]  LAT_LOAD = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_t      state, state_nxt;
  logic [3:0]  cnt;
  logic        cap_write;
  logic [2:0]  cap_size;
  logic [31:0] cap_addr;
  logic [31:0] cap_wdata;
  logic [31:0] mem [DEPTH_WORDS];

  logic             accept, commit, error, misaligned;
  logic             cur_write;
  logic [2:0]       cur_size;
  logic [31:0]      cur_addr, cur_wdata, offset, raw, load_data, wdata_lanes;
  logic [IDX_W-1:0] idx;
  logic [3:0]       byte_en;

  assign accept = (state == IDLE) && bus.req_valid;
  assign commit = (state_nxt == RESP) && (state != RESP);

  // With zero wait states the commit happens on the acceptance edge, so the
  // live request inputs are used while idle and the captured copy otherwise.
  assign cur_write = (state == IDLE) ? bus.req_write : cap_write;
  assign cur_size  = (state == IDLE) ? bus.req_size  : cap_size;
  assign cur_addr  = (state == IDLE) ? bus.req_addr  : cap_addr;
  assign cur_wdata = (state == IDLE) ? bus.req_wdata : cap_wdata;

  // Unsigned offset wraps for addresses below the base, so one compare covers both ends.
  assign offset = cur_addr - BASE_ADDR;
  assign idx    = offset[IDX_W+1:2];
  assign raw    = mem[idx];
  assign error  = (offset >= SPAN) || misaligned || !size_legal(cur_write, cur_size);

  mem_lane_align u_align (
    .addr_lo     (cur_addr[1:0]),
    .size        (cur_size),
    .wdata       (cur_wdata),
    .raw         (raw),
    .byte_en     (byte_en),
    .wdata_lanes (wdata_lanes),
    .load_data   (load_data),
    .misaligned  (misaligned)
  );

  // State register
  always_ff @(posedge clock or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = (LATENCY == 0) ? RESP : WAIT;
      WAIT:    if (cnt == 4'd0) state_nxt = RESP;
      RESP:    if (bus.resp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = (state == RESP);
  end

  // Request capture and wait-state counter
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt       <= 4'd0;
      cap_write <= 1'b0;
      cap_size  <= 3'd0;
      cap_addr  <= 32'h0;
      cap_wdata <= 32'h0;
    end else if (accept) begin
      cnt       <= LAT_LOAD;
      cap_write <= bus.req_write;
      cap_size  <= bus.req_size;
      cap_addr  <= bus.req_addr;
      cap_wdata <= bus.req_wdata;
    end else if ((state == WAIT) && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Response registers: loaded at commit, cleared once the response is taken
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bus.resp_rdata <= 32'h0;
      bus.resp_error <= 1'b0;
    end else if (commit) begin
      bus.resp_error <= error;
      bus.resp_rdata <= (error || cur_write) ? 32'h0 : load_data;
    end else if ((state == RESP) && bus.resp_ready) begin
      bus.resp_rdata <= 32'h0;
      bus.resp_error <= 1'b0;
    end
  end

  // Storage: lane-masked store at the commit edge
  always_ff @(posedge clock) begin
    // NOTE: the array has no reset; clearing it would cost a reset path on every bit for no functional gain.
    if (commit && !error && cur_write) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[idx][8*i +: 8] <= wdata_lanes[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_data_memory_responder.sv
// Directed bench for data_memory_responder: a LATENCY=2 instance covers
// sizes, errors, back-pressure and reset abort; a LATENCY=0 instance covers
// back-to-back throughput.
module tb_data_memory_responder;
  import data_memory_responder_pkg::*;

  logic clock;
  logic reset;
  int   n_cmp;
  int   n_fail;

  data_memory_responder_if b2 ();
  data_memory_responder_if b0 ();

  data_memory_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h1001_0000), .LATENCY(2)) dut (
    .clock (clock), .reset (reset), .bus (b2)
  );

  data_memory_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h1001_0000), .LATENCY(0)) dut0 (
    .clock (clock), .reset (reset), .bus (b0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One complete access on the LATENCY=2 instance; request inputs are
  // scrambled after acceptance so only the captured copy can matter.
  task automatic do_access(input logic w, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd,
                           output logic er, output int lat);
    int n;
    @(negedge clock);
    b2.req_valid = 1'b1; b2.req_write = w; b2.req_size = sz;
    b2.req_addr = a; b2.req_wdata = wd; b2.resp_ready = 1'b0;
    n = 0;
    while (!b2.req_ready && n < 20) begin @(negedge clock); n++; end
    @(posedge clock);
    @(negedge clock);
    b2.req_valid = 1'b0; b2.req_write = ~w; b2.req_size = 3'd7;
    b2.req_addr = ~a; b2.req_wdata = ~wd;
    lat = 1;
    while (!b2.resp_valid && lat < 20) begin @(negedge clock); lat++; end
    rd = b2.resp_rdata;
    er = b2.resp_error;
    b2.resp_ready = 1'b1;
    @(negedge clock);
    b2.resp_ready = 1'b0;
  endtask

  // Same access sequence on the LATENCY=0 instance.
  task automatic do_access0(input logic w, input logic [2:0] sz, input logic [31:0] a,
                            input logic [31:0] wd, output logic [31:0] rd,
                            output logic er, output int lat);
    int n;
    @(negedge clock);
    b0.req_valid = 1'b1; b0.req_write = w; b0.req_size = sz;
    b0.req_addr = a; b0.req_wdata = wd; b0.resp_ready = 1'b0;
    n = 0;
    while (!b0.req_ready && n < 20) begin @(negedge clock); n++; end
    @(posedge clock);
    @(negedge clock);
    b0.req_valid = 1'b0; b0.req_write = ~w; b0.req_size = 3'd7;
    b0.req_addr = ~a; b0.req_wdata = ~wd;
    lat = 1;
    while (!b0.resp_valid && lat < 20) begin @(negedge clock); lat++; end
    rd = b0.resp_rdata;
    er = b0.resp_error;
    b0.resp_ready = 1'b1;
    @(negedge clock);
    b0.resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    b2.req_valid = 1'b0; b2.req_write = 1'b0; b2.req_size = 3'd0;
    b2.req_addr = 32'h0; b2.req_wdata = 32'h0; b2.resp_ready = 1'b0;
    b0.req_valid = 1'b0; b0.req_write = 1'b0; b0.req_size = 3'd0;
    b0.req_addr = 32'h0; b0.req_wdata = 32'h0; b0.resp_ready = 1'b0;
    @(negedge clock);
    @(negedge clock);
    n_cmp++; if (b2.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst_req_ready: got %b want 1", b2.req_ready); end
    n_cmp++; if (b2.resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b want 0", b2.resp_valid); end
    n_cmp++; if (b2.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", b2.resp_rdata); end
    n_cmp++; if (b2.resp_error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b want 0", b2.resp_error); end
    n_cmp++; if (b0.req_ready !== 1'b1) begin n_fail++; $display("FAIL rst0_req_ready: got %b want 1", b0.req_ready); end
    reset = 1'b0;
  endtask

  task automatic test_word();
    logic [31:0] rd; logic er; int lat;
    do_access(1'b1, SIZE_W, 32'h1001_0004, 32'hDEAD_BEEF, rd, er, lat);
    n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL sw_latency: got %0d want 3", lat); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL sw_error: got %b want 0", er); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL sw_rdata: got %h want 0", rd); end
    do_access(1'b0, SIZE_W, 32'h1001_0004, 32'h0, rd, er, lat);
    n_cmp++; if (lat != 3) begin n_fail++; $display("FAIL lw_latency: got %0d want 3", lat); end
    n_cmp++; if (rd !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL lw_data: got %h want deadbeef", rd); end
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL lw_error: got %b want 0", er); end
    n_cmp++; if (b2.resp_valid !== 1'b0) begin n_fail++; $display("FAIL post_hs_valid: got %b want 0", b2.resp_valid); end
    n_cmp++; if (b2.resp_rdata !== 32'h0) begin n_fail++; $display("FAIL post_hs_rdata: got %h want 0", b2.resp_rdata); end
  endtask

  task automatic test_byte();
    logic [31:0] rd; logic er; int lat;
    do_access(1'b1, SIZE_B, 32'h1001_0005, 32'hAAAA_AA80, rd, er, lat);
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL sb_error: got %b want 0", er); end
    do_access(1'b0, SIZE_B, 32'h1001_0005, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hFFFF_FF80) begin n_fail++; $display("FAIL lb_data: got %h want ffffff80", rd); end
    do_access(1'b0, SIZE_BU, 32'h1001_0005, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h0000_0080) begin n_fail++; $display("FAIL lbu_data: got %h want 00000080", rd); end
    do_access(1'b0, SIZE_W, 32'h1001_0004, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hDEAD_80EF) begin n_fail++; $display("FAIL lw_after_sb: got %h want dead80ef", rd); end
  endtask

  task automatic test_half_and_errors();
    logic [31:0] rd; logic er; int lat;
    do_access(1'b0, SIZE_H, 32'h1001_0006, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hFFFF_DEAD) begin n_fail++; $display("FAIL lh_data: got %h want ffffdead", rd); end
    do_access(1'b0, SIZE_HU, 32'h1001_0006, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h0000_DEAD) begin n_fail++; $display("FAIL lhu_data: got %h want 0000dead", rd); end
    do_access(1'b0, SIZE_W, 32'h1001_0006, 32'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL lw_misalign_err: got %b want 1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL lw_misalign_rdata: got %h want 0", rd); end
    do_access(1'b0, SIZE_H, 32'h1001_0005, 32'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL lh_misalign_err: got %b want 1", er); end
    // word 0 gets a known value so an aliased out-of-range store would show
    do_access(1'b1, SIZE_W, 32'h1001_0000, 32'h0123_4567, rd, er, lat);
    n_cmp++; if (er !== 1'b0) begin n_fail++; $display("FAIL sw_word0_err: got %b want 0", er); end
    do_access(1'b1, SIZE_W, 32'h1001_0400, 32'hFFFF_FFFF, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL sw_range_err: got %b want 1", er); end
    do_access(1'b1, SIZE_BU, 32'h1001_0000, 32'h0000_00FF, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL store_bu_err: got %b want 1", er); end
    do_access(1'b0, SIZE_W, 32'h1001_0000, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'h0123_4567) begin n_fail++; $display("FAIL word0_unchanged: got %h want 01234567", rd); end
    do_access(1'b0, SIZE_W, 32'h1000_FFFC, 32'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL below_base_err: got %b want 1", er); end
    do_access(1'b0, 3'd3, 32'h1001_0000, 32'h0, rd, er, lat);
    n_cmp++; if (er !== 1'b1) begin n_fail++; $display("FAIL size3_err: got %b want 1", er); end
    n_cmp++; if (rd !== 32'h0) begin n_fail++; $display("FAIL size3_rdata: got %h want 0", rd); end
  endtask

  task automatic test_backpressure();
    int n;
    @(negedge clock);
    b2.req_valid = 1'b1; b2.req_write = 1'b0; b2.req_size = SIZE_W;
    b2.req_addr = 32'h1001_0004; b2.resp_ready = 1'b0;
    @(posedge clock);
    @(negedge clock);
    b2.req_addr = 32'h1001_0000;
    n = 0;
    while (!b2.resp_valid && n < 20) begin @(negedge clock); n++; end
    for (int k = 0; k < 5; k++) begin
      n_cmp++; if (b2.resp_valid !== 1'b1) begin n_fail++; $display("FAIL stall_valid[%0d]: got %b want 1", k, b2.resp_valid); end
      n_cmp++; if (b2.resp_rdata !== 32'hDEAD_80EF) begin n_fail++; $display("FAIL stall_rdata[%0d]: got %h want dead80ef", k, b2.resp_rdata); end
      n_cmp++; if (b2.req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_req_ready[%0d]: got %b want 0", k, b2.req_ready); end
      if (k < 4) @(negedge clock);
    end
    b2.resp_ready = 1'b1;
    @(negedge clock);
    b2.resp_ready = 1'b0;
    n_cmp++; if (b2.req_ready !== 1'b1) begin n_fail++; $display("FAIL release_req_ready: got %b want 1", b2.req_ready); end
    n_cmp++; if (b2.resp_valid !== 1'b0) begin n_fail++; $display("FAIL release_valid: got %b want 0", b2.resp_valid); end
    @(negedge clock);
    b2.req_valid = 1'b0;
    n_cmp++; if (b2.req_ready !== 1'b0) begin n_fail++; $display("FAIL held_req_taken: got req_ready %b want 0", b2.req_ready); end
    n = 0;
    while (!b2.resp_valid && n < 20) begin @(negedge clock); n++; end
    n_cmp++; if (b2.resp_rdata !== 32'h0123_4567) begin n_fail++; $display("FAIL held_req_data: got %h want 01234567", b2.resp_rdata); end
    b2.resp_ready = 1'b1;
    @(negedge clock);
    b2.resp_ready = 1'b0;
  endtask

  task automatic test_reset_mid_wait();
    logic [31:0] rd; logic er; int lat;
    do_access(1'b1, SIZE_W, 32'h1001_0008, 32'hCAFE_F00D, rd, er, lat);
    @(negedge clock);
    b2.req_valid = 1'b1; b2.req_write = 1'b1; b2.req_size = SIZE_W;
    b2.req_addr = 32'h1001_0008; b2.req_wdata = 32'h1234_5678;
    @(posedge clock);
    @(negedge clock);
    b2.req_valid = 1'b0;
    @(negedge clock);
    n_cmp++; if (b2.req_ready !== 1'b0) begin n_fail++; $display("FAIL in_wait_req_ready: got %b want 0", b2.req_ready); end
    reset = 1'b1;
    #1;
    n_cmp++; if (b2.req_ready !== 1'b1) begin n_fail++; $display("FAIL async_rst_req_ready: got %b want 1", b2.req_ready); end
    n_cmp++; if (b2.resp_valid !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %b want 0", b2.resp_valid); end
    @(negedge clock);
    reset = 1'b0;
    do_access(1'b0, SIZE_W, 32'h1001_0008, 32'h0, rd, er, lat);
    n_cmp++; if (rd !== 32'hCAFE_F00D) begin n_fail++; $display("FAIL aborted_store: got %h want cafef00d", rd); end
  endtask

  task automatic test_latency0();
    logic [31:0] rd; logic er; int lat;
    int hits;
    do_access0(1'b1, SIZE_W, 32'h1001_0010, 32'h0BAD_F00D, rd, er, lat);
    n_cmp++; if (lat != 1) begin n_fail++; $display("FAIL l0_sw_latency: got %0d want 1", lat); end
    @(negedge clock);
    b0.req_valid = 1'b1; b0.req_write = 1'b0; b0.req_size = SIZE_W;
    b0.req_addr = 32'h1001_0010; b0.resp_ready = 1'b1;
    hits = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      n_cmp++; if (b0.resp_valid !== ((i % 2) == 0)) begin n_fail++; $display("FAIL l0_valid[%0d]: got %b want %b", i, b0.resp_valid, (i % 2) == 0); end
      if (b0.resp_valid === 1'b1) begin
        hits++;
        n_cmp++; if (b0.resp_rdata !== 32'h0BAD_F00D) begin n_fail++; $display("FAIL l0_rdata[%0d]: got %h want 0badf00d", i, b0.resp_rdata); end
      end
    end
    b0.req_valid = 1'b0;
    b0.resp_ready = 1'b0;
    n_cmp++; if (hits != 4) begin n_fail++; $display("FAIL l0_throughput: got %0d responses want 4", hits); end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_word();
    test_byte();
    test_half_and_errors();
    test_backpressure();
    test_reset_mid_wait();
    test_latency0();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
